// File: rtl/l1_mem_port_arbiter_if.sv
// rtl/l1_mem_port_arbiter_if.sv - inst cache, data cache and memory port signals of the L1 port arbiter
interface l1_mem_port_arbiter_if;
    logic        iINST_REQ;
    logic        oINST_LOCK;
    logic [31:0] iINST_ADDR;
    logic        oINST_VALID;
    logic [63:0] oINST_DATA;
    logic        iINST_BUSY;

    logic        iDATA_REQ;
    logic        oDATA_LOCK;
    logic        iDATA_RW;
    logic [31:0] iDATA_ADDR;
    logic [7:0]  iDATA_MASK;
    logic [63:0] iDATA_WDATA;
    logic        oDATA_VALID;
    logic [63:0] oDATA_RDATA;
    logic        iDATA_BUSY;

    logic        oMEM_REQ;
    logic        iMEM_LOCK;
    logic        oMEM_RW;
    logic [31:0] oMEM_ADDR;
    logic [7:0]  oMEM_MASK;
    logic [63:0] oMEM_DATA;
    logic        iMEM_VALID;
    logic        oMEM_BUSY;
    logic [63:0] iMEM_DATA;

    // Arbiter side
    modport slave (
        input  iINST_REQ, iINST_ADDR, iINST_BUSY,
        input  iDATA_REQ, iDATA_RW, iDATA_ADDR, iDATA_MASK, iDATA_WDATA, iDATA_BUSY,
        input  iMEM_LOCK, iMEM_VALID, iMEM_DATA,
        output oINST_LOCK, oINST_VALID, oINST_DATA,
        output oDATA_LOCK, oDATA_VALID, oDATA_RDATA,
        output oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_MASK, oMEM_DATA, oMEM_BUSY
    );

    // Caches and memory side
    modport master (
        output iINST_REQ, iINST_ADDR, iINST_BUSY,
        output iDATA_REQ, iDATA_RW, iDATA_ADDR, iDATA_MASK, iDATA_WDATA, iDATA_BUSY,
        output iMEM_LOCK, iMEM_VALID, iMEM_DATA,
        input  oINST_LOCK, oINST_VALID, oINST_DATA,
        input  oDATA_LOCK, oDATA_VALID, oDATA_RDATA,
        input  oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_MASK, oMEM_DATA, oMEM_BUSY
    );
endinterface

// File: rtl/l1_mem_port_arbiter.sv
// rtl/l1_mem_port_arbiter.sv - shares one memory port between L1 inst refills and L1 data accesses
module l1_mem_port_arbiter #(
    parameter int P_INST_BURST = 8
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iRESET_SYNC,
    l1_mem_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_INST_REQ,
        S_INST_WAIT,
        S_DATA_REQ,
        S_DATA_WAIT
    } state_t;

    localparam logic [3:0] L_BURST = 4'(P_INST_BURST);
    localparam logic [3:0] L_LAST  = 4'(P_INST_BURST - 1);

    state_t     state;
    logic [3:0] req_cnt;
    logic [3:0] rsp_cnt;
    logic       last_grant;

    logic       inst_phase;
    logic       inst_beat_acc;
    logic       inst_rsp_acc;
    logic       data_beat_acc;
    logic       data_rsp_acc;
    logic [3:0] rsp_next;

    assign inst_phase    = (state == S_INST_REQ) || (state == S_INST_WAIT);
    assign inst_beat_acc = (state == S_INST_REQ) && bus.iINST_REQ && !bus.iMEM_LOCK;
    assign inst_rsp_acc  = inst_phase && bus.iMEM_VALID && !bus.iINST_BUSY;
    assign data_beat_acc = (state == S_DATA_REQ) && bus.iDATA_REQ && !bus.iMEM_LOCK;
    assign data_rsp_acc  = (state == S_DATA_WAIT) && bus.iMEM_VALID && !bus.iDATA_BUSY;
    assign rsp_next      = rsp_cnt + {3'b000, inst_rsp_acc};

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state      <= S_IDLE;
            req_cnt    <= 4'd0;
            rsp_cnt    <= 4'd0;
            last_grant <= 1'b1;
        end else if (iRESET_SYNC) begin
            state      <= S_IDLE;
            req_cnt    <= 4'd0;
            rsp_cnt    <= 4'd0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    // On a tie the requester that did not win last time is served
                    if (bus.iINST_REQ && (!bus.iDATA_REQ || last_grant)) begin
                        state      <= S_INST_REQ;
                        last_grant <= 1'b0;
                    end else if (bus.iDATA_REQ) begin
                        state      <= S_DATA_REQ;
                        last_grant <= 1'b1;
                    end
                end
                S_INST_REQ: begin
                    rsp_cnt <= rsp_next;
                    if (inst_beat_acc) begin
                        if (req_cnt == L_LAST) begin
                            req_cnt <= 4'd0;
                            // A fast memory may already have returned every response
                            if (rsp_next == L_BURST) begin
                                state   <= S_IDLE;
                                rsp_cnt <= 4'd0;
                            end else begin
                                state <= S_INST_WAIT;
                            end
                        end else begin
                            req_cnt <= req_cnt + 4'd1;
                        end
                    end
                end
                S_INST_WAIT: begin
                    if (inst_rsp_acc) begin
                        if (rsp_cnt == L_LAST) begin
                            state   <= S_IDLE;
                            rsp_cnt <= 4'd0;
                        end else begin
                            rsp_cnt <= rsp_cnt + 4'd1;
                        end
                    end
                end
                S_DATA_REQ: begin
                    if (data_beat_acc) begin
                        state <= bus.iDATA_RW ? S_IDLE : S_DATA_WAIT;
                    end
                end
                S_DATA_WAIT: begin
                    if (data_rsp_acc) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.oINST_LOCK  = 1'b1;
        bus.oDATA_LOCK  = 1'b1;
        bus.oMEM_REQ    = 1'b0;
        bus.oMEM_RW     = 1'b0;
        bus.oMEM_ADDR   = 32'd0;
        bus.oMEM_MASK   = 8'd0;
        bus.oMEM_DATA   = 64'd0;
        bus.oMEM_BUSY   = 1'b0;
        bus.oINST_VALID = 1'b0;
        bus.oINST_DATA  = 64'd0;
        bus.oDATA_VALID = 1'b0;
        bus.oDATA_RDATA = 64'd0;
        if (state == S_INST_REQ) begin
            bus.oMEM_REQ   = bus.iINST_REQ;
            bus.oINST_LOCK = bus.iMEM_LOCK;
            bus.oMEM_ADDR  = bus.iINST_ADDR;
            bus.oMEM_MASK  = 8'hFF;
        end
        if (inst_phase) begin
            bus.oINST_VALID = bus.iMEM_VALID;
            bus.oINST_DATA  = bus.iMEM_DATA;
            bus.oMEM_BUSY   = bus.iINST_BUSY;
        end
        if (state == S_DATA_REQ) begin
            bus.oMEM_REQ   = bus.iDATA_REQ;
            bus.oDATA_LOCK = bus.iMEM_LOCK;
            bus.oMEM_RW    = bus.iDATA_RW;
            bus.oMEM_ADDR  = bus.iDATA_ADDR;
            bus.oMEM_MASK  = bus.iDATA_MASK;
            bus.oMEM_DATA  = bus.iDATA_WDATA;
        end
        if (state == S_DATA_WAIT) begin
            bus.oDATA_VALID = bus.iMEM_VALID;
            bus.oDATA_RDATA = bus.iMEM_DATA;
            bus.oMEM_BUSY   = bus.iDATA_BUSY;
        end
    end

    // Responses with no owner are dropped; they point at a memory-side protocol bug
    a_no_stray_rsp: assert property (@(posedge iCLOCK) disable iff (!inRESET || iRESET_SYNC)
        !(bus.iMEM_VALID && ((state == S_IDLE) || (state == S_DATA_REQ))))
        else $error("memory response with no owner dropped");
endmodule
